// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request and response bus between core and data memory
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [15:0] store_count;
  modport master (output req, we, addr, wdata, be, input rdata, ready, err, store_count);
  modport slave  (input req, we, addr, wdata, be, output rdata, ready, err, store_count);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data memory with byte-enabled stores, error flagging and a store counter
module dmem_responder #(
  parameter int          ADDR_BITS = 10,
  parameter logic [31:0] BASE      = 32'h0000_0000,
  parameter int          WAIT      = 2
) (
  input logic clk,
  input logic reset,
  dmem_responder_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);
  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic                  ready_q;
  logic                  err_q;
  logic [15:0]           store_count_q;
  logic [31:0]           rd_q;
  logic [31:0]           mem [2**ADDR_BITS];
  logic [31:0]           cur_addr;
  logic [31:0]           off;
  logic                  cur_err;
  logic [ADDR_BITS-1:0]  idx;
  // In IDLE the incoming address is used so a zero-wait access can read on its accepting edge
  assign cur_addr = (state_q == S_IDLE) ? bus.addr : addr_q;
  assign off      = cur_addr - BASE;
  assign cur_err  = (cur_addr[1:0] != 2'b00) || (cur_addr < BASE) || ((off >> (ADDR_BITS + 2)) != 32'd0);
  assign idx      = off[ADDR_BITS+1:2];
  // Request sequencing: latch on accept, count wait states, pulse a one-cycle response
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      ready_q       <= 1'b0;
      err_q         <= 1'b0;
      store_count_q <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.req) begin
          we_q    <= bus.we;
          addr_q  <= bus.addr;
          wdata_q <= bus.wdata;
          be_q    <= bus.be;
          cnt_q   <= WAIT_CNT;
          if (WAIT == 0) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            err_q   <= cur_err;
          end else state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            err_q   <= cur_err;
          end
        end
        default: begin
          state_q <= S_IDLE;
          if (we_q && !err_q && store_count_q != 16'hFFFF) store_count_q <= store_count_q + 16'd1;
        end
      endcase
    end
  // Single-port array: store commits on the edge ending RESP, read captured on every edge
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && we_q && !err_q)
      for (int b = 0; b < 4; b++) if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
    rd_q <= mem[idx];
  end
  assign bus.ready       = ready_q;
  assign bus.err         = err_q;
  assign bus.rdata       = (ready_q && !we_q && !err_q) ? rd_q : 32'd0;
  assign bus.store_count = store_count_q;
endmodule
